// File: rtl/rx_pkg.sv
// Shared definitions for the serial frame receiver: frame geometry, CRC-8
// polynomial, receiver state encoding and the bit-serial CRC step.
package rx_pkg;

    localparam int PACKET_BITS  = 136;
    localparam int CRC_BITS     = 8;
    localparam int PAYLOAD_BITS = PACKET_BITS - CRC_BITS;

    localparam logic [CRC_BITS-1:0] CRC_POLY = 8'h07;

    localparam int PAYLOAD_MSB = PACKET_BITS - 1;
    localparam int PAYLOAD_LSB = CRC_BITS;
    localparam int CRC_MSB     = CRC_BITS - 1;
    localparam int CRC_LSB     = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    // One MSB-first CRC-8 step: shift left, fold in the polynomial when the
    // outgoing bit differs from the incoming data bit.
    function automatic logic [CRC_BITS-1:0] crc8_step(input logic [CRC_BITS-1:0] crc,
                                                      input logic              b);
        logic fb;
        fb = crc[CRC_BITS-1] ^ b;
        return {crc[CRC_BITS-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    endfunction

endpackage

// File: rtl/rx_crc8.sv
// Bit-serial CRC-8 engine (init 0, no reflection, no final XOR).
// clr has priority over en; usable by both receive and transmit paths.
module rx_crc8
    import rx_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                en,
    input  logic                bit_in,
    output logic [CRC_BITS-1:0] crc
);

    logic [CRC_BITS-1:0] crc_q;
    logic [CRC_BITS-1:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr) begin
            crc_d = '0;
        end else if (en) begin
            crc_d = crc8_step(crc_q, bit_in);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/rx_receiver.sv
// Serial frame receiver: start bit, 136 data bits MSB first, stop bit, with
// CRC-8 check over the 128-bit payload. Optional error counter: RX_ERR_COUNT_EN.
module rx_receiver
    import rx_pkg::*;
#(
    parameter int BIT_CYCLES = 5208
)
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx_line,
    output logic [PACKET_BITS-1:0] rx_packet,
    output logic                   rx_valid,
    output logic                   crc_ok,
    output logic                   frame_err,
    output logic                   rx_busy,
    output logic [15:0]            err_count
);

    localparam int              CNT_W    = $clog2(BIT_CYCLES);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(BIT_CYCLES / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIT_CYCLES - 1);
    localparam logic [7:0]      LAST_IDX = 8'(PACKET_BITS - 1);
    localparam logic [7:0]      CRC_IDX  = 8'(PAYLOAD_BITS);

    logic       sync1_q;
    logic       sync2_q;
    logic       prev_q;
    logic [1:0] fill_q;
    logic       armed_q;
    logic       fall_edge;

    rx_state_e               state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [7:0]              idx_q, idx_d;
    logic [PACKET_BITS-1:0]  shift_q, shift_d;
    logic [PACKET_BITS-1:0]  rx_packet_q, rx_packet_d;
    logic                    crc_ok_q, crc_ok_d;
    logic                    frame_err_q, frame_err_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    crc_clr;
    logic                    crc_en;
    logic [CRC_BITS-1:0]     crc_val;

    // The arm flag only sets once a genuinely sampled high level has passed
    // the synchroniser, so a line held low through reset cannot start a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            fill_q  <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            sync1_q <= rx_line;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            fill_q  <= {fill_q[0], 1'b1};
            armed_q <= armed_q | (fill_q[1] & sync2_q);
        end
    end

    assign fall_edge = armed_q & prev_q & ~sync2_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        idx_d       = idx_q;
        shift_d     = shift_q;
        rx_packet_d = rx_packet_q;
        crc_ok_d    = crc_ok_q;
        frame_err_d = frame_err_q;
        rx_valid_d  = 1'b0;
        crc_clr     = 1'b0;
        crc_en      = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (fall_edge) begin
                    state_d = START;
                    crc_clr = 1'b1;
                end
            end
            START: begin
                if (cnt_q == HALF_CNT) begin
                    state_d = sync2_q ? IDLE : DATA;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    shift_d = {shift_q[PACKET_BITS-2:0], sync2_q};
                    crc_en  = (idx_q < CRC_IDX);
                    idx_d   = idx_q + 8'd1;
                    if (idx_q == LAST_IDX) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt_q == LAST_CNT) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    rx_packet_d = shift_q;
                    crc_ok_d    = (crc_val == shift_q[CRC_MSB:CRC_LSB]);
                    frame_err_d = ~sync2_q;
                    rx_valid_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            rx_packet_q <= '0;
            crc_ok_q    <= 1'b0;
            frame_err_q <= 1'b0;
            rx_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            rx_packet_q <= rx_packet_d;
            crc_ok_q    <= crc_ok_d;
            frame_err_q <= frame_err_d;
            rx_valid_q  <= rx_valid_d;
        end
    end

    rx_crc8 u_crc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (crc_clr),
        .en     (crc_en),
        .bit_in (sync2_q),
        .crc    (crc_val)
    );

`ifdef RX_ERR_COUNT_EN
    logic [15:0] err_count_q;

    // Counted alongside the status update so err_count is current during rx_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_q <= '0;
        end else if (rx_valid_d && (!crc_ok_d || frame_err_d) && (err_count_q != 16'hFFFF)) begin
            err_count_q <= err_count_q + 16'd1;
        end
    end

    assign err_count = err_count_q;
`else
    assign err_count = 16'h0000;
`endif

    assign rx_packet = rx_packet_q;
    assign rx_valid  = rx_valid_q;
    assign crc_ok    = crc_ok_q;
    assign frame_err = frame_err_q;
    assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_rx_receiver.sv
// Directed testbench for rx_receiver with a queue-based scoreboard; expected
// frame results are queued by the stimulus and consumed by an rx_valid monitor.
module tb_rx_receiver;

    localparam int BC = 8;

    localparam logic [127:0] CHK_PAYLOAD = 128'h0000_0000_0000_0031_3233_3435_3637_3839;
    localparam logic [7:0]   CHK_CRC     = 8'hF4;
    localparam logic [127:0] A5_PAYLOAD  = 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5;
    localparam logic [127:0] SEQ_PAYLOAD = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    typedef struct {
        logic [135:0] pkt;
        logic         crcOk;
        logic         frameErr;
        logic [15:0]  errCnt;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         rx_line;
    logic [135:0] rx_packet;
    logic         rx_valid;
    logic         crc_ok;
    logic         frame_err;
    logic         rx_busy;
    logic [15:0]  err_count;

    exp_t         expQ[$];
    exp_t         monE;
    logic [15:0]  errExp;
    logic [135:0] lastPkt;
    logic         sawBusy;
    int           passCount;
    int           checkCount;

    rx_receiver #(.BIT_CYCLES(BC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_line   (rx_line),
        .rx_packet (rx_packet),
        .rx_valid  (rx_valid),
        .crc_ok    (crc_ok),
        .frame_err (frame_err),
        .rx_busy   (rx_busy),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [135:0] act, input logic [135:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] crc8Model(input logic [127:0] payload);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 127; i >= 0; i--) begin
            fb = c[7] ^ payload[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    task automatic sendBit(input logic b);
        rx_line = b;
        repeat (BC) @(negedge clk);
    endtask

    // Sends one frame; abortAt >= 0 stops before that data bit and queues nothing.
    task automatic applyStimulus(input logic [135:0] pkt, input logic stopBit,
                                 input logic expCrcOk, input int abortAt);
        exp_t e;
        if (abortAt < 0) begin
`ifdef RX_ERR_COUNT_EN
            if ((!expCrcOk || !stopBit) && errExp != 16'hFFFF) errExp = errExp + 16'd1;
`endif
            e.pkt      = pkt;
            e.crcOk    = expCrcOk;
            e.frameErr = ~stopBit;
            e.errCnt   = errExp;
            expQ.push_back(e);
            lastPkt    = pkt;
        end
        sendBit(1'b0);
        for (int i = 0; i < 136; i++) begin
            if (i == abortAt) return;
            sendBit(pkt[135 - i]);
        end
        sendBit(stopBit);
        rx_line = 1'b1;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((expQ.size() != 0 || rx_busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drainQueue", 136'(expQ.size()), 136'd0);
        checkOutput("busyAfterFrame", 136'(rx_busy), 136'd0);
    endtask

    task automatic checkReset();
        checkOutput("resetPacket",   rx_packet,       136'd0);
        checkOutput("resetValid",    136'(rx_valid),  136'd0);
        checkOutput("resetCrcOk",    136'(crc_ok),    136'd0);
        checkOutput("resetFrameErr", 136'(frame_err), 136'd0);
        checkOutput("resetBusy",     136'(rx_busy),   136'd0);
        checkOutput("resetErrCount", 136'(err_count), 136'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && rx_valid) begin
            if (expQ.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL unexpectedValid: got rx_valid=1 with no frame pending, expected 0");
            end else begin
                monE = expQ.pop_front();
                checkOutput("rxPacket", rx_packet, monE.pkt);
                checkOutput("crcOk", 136'(crc_ok), 136'(monE.crcOk));
                checkOutput("frameErr", 136'(frame_err), 136'(monE.frameErr));
                checkOutput("errCount", 136'(err_count), 136'(monE.errCnt));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        passCount  = 0;
        checkCount = 0;
        errExp     = 16'h0000;
        lastPkt    = '0;
        rst_n      = 1'b0;
        rx_line    = 1'b0;
        repeat (3) @(negedge clk);
        checkReset();

        // Line low at reset release must not start a frame.
        rst_n   = 1'b1;
        sawBusy = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (rx_busy) sawBusy = 1'b1;
        end
        checkOutput("lowAtReleaseBusy", 136'(sawBusy), 136'd0);
        rx_line = 1'b1;
        repeat (6) @(negedge clk);

        $display("[TB] test 1: zero payload, good CRC");
        applyStimulus({128'd0, 8'h00}, 1'b1, 1'b1, -1);
        waitIdle();

        $display("[TB] test 2: zero payload, bad CRC");
        applyStimulus({128'd0, 8'h01}, 1'b1, 1'b0, -1);
        waitIdle();

        $display("[TB] test 3: stop bit low, good then bad CRC");
        applyStimulus({CHK_PAYLOAD, CHK_CRC}, 1'b0, 1'b1, -1);
        waitIdle();
        applyStimulus({CHK_PAYLOAD, 8'h00}, 1'b0, 1'b0, -1);
        waitIdle();

        $display("[TB] test 4: 3-clock glitch on idle line");
        sawBusy = 1'b0;
        rx_line = 1'b0;
        repeat (3) @(negedge clk);
        rx_line = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (rx_busy) sawBusy = 1'b1;
        end
        checkOutput("glitchBusySeen", 136'(sawBusy), 136'd1);
        checkOutput("glitchBusyClear", 136'(rx_busy), 136'd0);
        checkOutput("glitchPacketHeld", rx_packet, lastPkt);

        $display("[TB] test 5: reset mid-frame then clean A5 frame");
        applyStimulus({A5_PAYLOAD, crc8Model(A5_PAYLOAD)}, 1'b1, 1'b1, 60);
        checkOutput("midFrameBusy", 136'(rx_busy), 136'd1);
        rst_n = 1'b0;
        #1;
        checkReset();
        rx_line = 1'b1;
        errExp  = 16'h0000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        applyStimulus({A5_PAYLOAD, crc8Model(A5_PAYLOAD)}, 1'b1, 1'b1, -1);
        waitIdle();

        $display("[TB] test 6: back-to-back frames");
        applyStimulus({CHK_PAYLOAD, CHK_CRC}, 1'b1, 1'b1, -1);
        applyStimulus({SEQ_PAYLOAD, crc8Model(SEQ_PAYLOAD)}, 1'b1, 1'b1, -1);
        waitIdle();
        checkOutput("finalPacketHeld", rx_packet, {SEQ_PAYLOAD, crc8Model(SEQ_PAYLOAD)});

        repeat (10) @(negedge clk);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
